// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the single-cycle MIPS core.
// Receives a framed byte stream (16-bit big-endian word count, payload, XOR
// checksum), writes big-endian words into instruction memory and holds the
// core in reset until a complete, checksum-valid image has been loaded.
// CPU_RST_HOLD must be at least 1.
module imem_loader #(
  parameter int ADDR_W       = 8,
  parameter int CPU_RST_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam int MAX_WORDS = 2 ** ADDR_W;
  localparam int CNT_W     = ADDR_W + 1;
  localparam int HOLD_W    = (CPU_RST_HOLD > 1) ? $clog2(CPU_RST_HOLD) : 1;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(CPU_RST_HOLD - 1);

  localparam logic [2:0] ST_LEN_HI  = 3'd0;
  localparam logic [2:0] ST_LEN_LO  = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_ERROR   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic        receiving;
  logic        accept;
  logic [15:0] len_full;

  assign receiving  = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHECK);
  assign in_ready   = rst && receiving;
  assign accept     = in_valid && in_ready;

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign error      = error_q;

  // Next-state logic: frame parsing, word assembly, checksum and core release.
  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    csum_d       = csum_q;
    hold_cnt_d   = hold_cnt_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_rst_d    = cpu_rst_q;
    done_d       = done_q;
    error_d      = error_q;
    len_full     = {len_hi_q, in_data};

    case (state_q)
      ST_LEN_HI: begin
        if (accept) begin
          len_hi_d = in_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          if ({16'd0, len_full} > 32'(MAX_WORDS)) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = ST_CHECK;
          end else begin
            state_d    = ST_DATA;
            len_d      = CNT_W'(len_full);
            word_cnt_d = '0;
            byte_cnt_d = 2'd0;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ in_data;
          asm_d      = {asm_q[15:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q[ADDR_W-1:0];
            imem_wdata_d = {asm_q, in_data};
            word_cnt_d   = word_cnt_q + CNT_ONE;
            if ((word_cnt_q + CNT_ONE) == len_q) begin
              state_d = ST_CHECK;
            end
          end
        end
      end
      ST_CHECK: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d    = ST_RELEASE;
            hold_cnt_d = '0;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        if (hold_cnt_q == HOLD_END) begin
          state_d   = ST_DONE;
          cpu_rst_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_LEN_HI;
          cpu_rst_d  = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          csum_d     = 8'd0;
          word_cnt_d = '0;
          byte_cnt_d = 2'd0;
        end
      end
      default: begin
        state_d = ST_LEN_HI;
      end
    endcase
  end

  // State and output registers; asynchronous active-low reset aborts any load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_LEN_HI;
      len_hi_q     <= 8'd0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= 2'd0;
      asm_q        <= 24'd0;
      csum_q       <= 8'd0;
      hold_cnt_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      csum_q       <= csum_d;
      hold_cnt_q   <= hold_cnt_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader.
// A frame-level reference model predicts the memory writes and the final
// outcome; a monitor pops the predicted writes whenever imem_we is seen.
module tb_imem_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  typedef logic [7:0] byteq_t[$];
  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              start = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;

  wr_t expQ[$];
  wr_t popped;
  int  checks = 0;
  int  passes = 0;
  int  writeCount = 0;

  imem_loader #(.ADDR_W(ADDR_W), .CPU_RST_HOLD(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe is matched against the oldest predicted write.
  always @(negedge clk) begin
    if (rst && imem_we) begin
      writeCount++;
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", imem_addr, imem_wdata);
      end else begin
        popped = expQ.pop_front();
        checkOutput("write_addr", {24'd0, imem_addr}, {24'd0, popped.addr});
        checkOutput("write_data", imem_wdata, popped.data);
      end
    end
  end

  // Reference model: parse a whole frame, queue expected writes, predict outcome.
  task automatic modelFrame(input byteq_t f, output bit expDone, output bit expErr, output int nWrites);
    int n;
    logic [7:0] x;
    logic [31:0] word;
    n = int'(f[0]) * 256 + int'(f[1]);
    x = 8'd0;
    expDone = 1'b0;
    expErr = 1'b1;
    nWrites = 0;
    if (n > MAX_WORDS) return;
    for (int w = 0; w < n; w++) begin
      word = {f[2+4*w], f[3+4*w], f[4+4*w], f[5+4*w]};
      x = x ^ f[2+4*w] ^ f[3+4*w] ^ f[4+4*w] ^ f[5+4*w];
      expQ.push_back('{addr: 8'(w), data: word});
    end
    nWrites = n;
    expDone = (f[2+4*n] == x);
    expErr = !expDone;
  endtask

  // Offer one byte (entered and left at a negedge), bounded wait for in_ready.
  task automatic sendByte(input logic [7:0] b);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      $display("[TB] FAIL byte_accept: got in_ready 0, expected 1 for byte 0x%0h", b);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input byteq_t f, input bit gapped);
    for (int i = 0; i < f.size(); i++) begin
      if (gapped && i > 0 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
        repeat (3) @(negedge clk);
      end
      sendByte(f[i]);
    end
  endtask

  // Wait (bounded) for the final state, then compare it with the model.
  task automatic waitEnd(input bit expDone, input bit expErr, input int nWrites);
    int guard;
    guard = 0;
    while (!(done || error) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    checkOutput("done", {31'd0, done}, {31'd0, expDone});
    checkOutput("error", {31'd0, error}, {31'd0, expErr});
    checkOutput("cpu_rst", {31'd0, cpu_rst}, {31'd0, !expDone});
    checkOutput("in_ready_final", {31'd0, in_ready}, 32'd0);
    checkOutput("pending_writes", expQ.size(), 32'd0);
    checkOutput("write_count", writeCount, nWrites);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("restart_error", {31'd0, error}, 32'd0);
    checkOutput("restart_done", {31'd0, done}, 32'd0);
    checkOutput("restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    checkOutput("restart_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic runFrame(input byteq_t f, input bit gapped);
    bit eDone, eErr;
    int nW;
    writeCount = 0;
    modelFrame(f, eDone, eErr, nW);
    applyStimulus(f, gapped);
    waitEnd(eDone, eErr, nW);
    pulseStart();
  endtask

  task automatic buildRandom(input int n, input bit goodCsum, output byteq_t f);
    logic [7:0] x;
    logic [7:0] b;
    f = {};
    x = 8'd0;
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      f.push_back(b);
    end
    if (!goodCsum) x = x ^ 8'($urandom_range(1, 255));
    f.push_back(x);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    byteq_t nominal;
    byteq_t f;
    bit eDone, eErr;
    int nW;
    nominal = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h0A, 8'h83};

    repeat (3) @(negedge clk);
    checkOutput("reset_imem_we", {31'd0, imem_we}, 32'd0);
    checkOutput("reset_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_error", {31'd0, error}, 32'd0);
    checkOutput("reset_wdata", imem_wdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Nominal back-to-back load with explicit release timing.
    writeCount = 0;
    modelFrame(nominal, eDone, eErr, nW);
    applyStimulus(nominal, 1'b0);
    checkOutput("release_cyc1_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    @(negedge clk);
    checkOutput("release_cyc2_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    @(negedge clk);
    checkOutput("release_cpu_rst_low", {31'd0, cpu_rst}, 32'd0);
    checkOutput("release_done", {31'd0, done}, 32'd1);
    waitEnd(eDone, eErr, nW);
    pulseStart();

    // Bad checksum.
    f = nominal;
    f[10] = 8'h84;
    runFrame(f, 1'b0);

    // Oversize length, zero length good and bad.
    runFrame('{8'h01, 8'h01}, 1'b0);
    runFrame('{8'h00, 8'h00, 8'h00}, 1'b0);
    runFrame('{8'h00, 8'h00, 8'hFF}, 1'b0);

    // Gapped nominal frame.
    runFrame(nominal, 1'b1);

    // Reset after the fifth payload byte, then a full reload.
    writeCount = 0;
    modelFrame(nominal, eDone, eErr, nW);
    for (int i = 0; i < 7; i++) sendByte(nominal[i]);
    rst = 1'b0;
    #1;
    checkOutput("midreset_imem_we", {31'd0, imem_we}, 32'd0);
    checkOutput("midreset_addr", {24'd0, imem_addr}, 32'd0);
    checkOutput("midreset_wdata", imem_wdata, 32'd0);
    checkOutput("midreset_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    checkOutput("midreset_done", {31'd0, done}, 32'd0);
    checkOutput("midreset_error", {31'd0, error}, 32'd0);
    checkOutput("midreset_writes", writeCount, 32'd1);
    expQ.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    runFrame(nominal, 1'b0);

    // Randomized frames, random gaps and checksum corruption.
    for (int k = 0; k < 8; k++) begin
      buildRandom($urandom_range(1, 6), ($urandom_range(0, 3) != 0), f);
      runFrame(f, $urandom_range(0, 1) == 1);
    end

    // Largest legal image: last write lands at address MAX_WORDS-1.
    buildRandom(MAX_WORDS, 1'b1, f);
    runFrame(f, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
